// File: rtl/mux_tdm_n_pkg.sv
// mux_tdm_n_pkg: constants shared by the TDM multiplexer and its arbiter.
//   clog2      - ceiling log2, never less than 1, for sizing channel indexes
//   MODE_FIXED - mode input value selecting the channel given by sel
//   MODE_SCAN  - mode input value selecting round-robin scanning
package mux_tdm_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // A single-channel index still needs one bit, so the result floors at 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_tdm_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req         [CH]   - request bit per channel
//   ptr         [SELW] - last granted channel; the search starts just after it
//   grant       [SELW] - first requesting channel found at ptr+1, ptr+2, ... mod CH
//   grant_valid [1]    - at least one request was found
module rr_arbiter #(
  parameter int CH   = 16,
  parameter int SELW = 4
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  int idx;

  // Offset CH wraps back to ptr itself, so a lone requester at ptr still wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 1; off <= CH; off++) begin
      idx = (int'(ptr) + off) % CH;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_tdm_n.sv
// mux_tdm_n: N-channel time-division multiplexer with a registered output.
//   clk, rst   - single clock, synchronous active-high reset
//   in_data    - CH words of WIDTH bits, channel i at [i*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel accept strobe (combinational, at most one bit set)
//   mode       - MODE_FIXED: take channel sel; MODE_SCAN: round-robin scan
//   sel        - channel index used in fixed mode (sel >= CH grants nothing)
//   out_data   - registered selected word
//   out_ch     - registered index of the channel that supplied out_data
//   out_valid  - registered output valid
//   out_ready  - downstream accept
module mux_tdm_n
  import mux_tdm_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 16,
  parameter int SELW  = clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic [SELW-1:0]  arb_grant;
  logic             arb_valid;
  logic [SELW-1:0]  grant_ch;
  logic             grant_ok;
  logic             xfer;

  rr_arbiter #(
    .CH   (CH),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // The output register may take a new word when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // grant_ok already folds in the granted channel's valid, so a transfer
  // is just load plus grant; reset suppresses every handshake.
  always_comb begin
    grant_ch = '0;
    grant_ok = 1'b0;
    if (mode == MODE_SCAN) begin
      grant_ch = arb_grant;
      grant_ok = arb_valid;
    end else if (int'(sel) < CH) begin
      grant_ch = sel;
      grant_ok = in_valid[sel];
    end
  end

  assign xfer = !rst && load && grant_ok;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = in_data[int'(grant_ch)*WIDTH +: WIDTH];
      out_ch_d   = grant_ch;
      // Fixed-mode traffic leaves the scan position untouched.
      if (mode == MODE_SCAN) ptr_d = grant_ch;
    end
  end

  // Output register stage; ptr resets to CH-1 so the first scan hits channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
